// File: rtl/mix_single_column.sv
// AES MixColumns / InvMixColumns on one 32-bit state column.
// Purely combinational GF(2^8) XOR/xtime datapath, registered once:
// one result per accepted input, one cycle of latency, no backpressure.
module mix_single_column #(
  parameter bit ENABLE_INV = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        inv,
  input  logic [31:0] in_column,
  output logic        out_valid,
  output logic [31:0] out_column
);

  // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward matrix rows [02 03 01 01] rotated; 3*b is built as 2*b ^ b.
  function automatic logic [31:0] fwd_mix(input logic [31:0] col);
    logic [7:0] s [4];
    logic [7:0] m2 [4];
    logic [7:0] r [4];
    for (int i = 0; i < 4; i++) begin
      s[i]  = col[31-8*i -: 8];
      m2[i] = xtime(s[i]);
    end
    for (int i = 0; i < 4; i++) begin
      r[i] = m2[i] ^ m2[(i+1)%4] ^ s[(i+1)%4] ^ s[(i+2)%4] ^ s[(i+3)%4];
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  // Inverse matrix rows [0E 0B 0D 09] rotated, composed from 2b, 4b, 8b.
  function automatic logic [31:0] inv_mix(input logic [31:0] col);
    logic [7:0] s [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] me [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] m9 [4];
    logic [7:0] r [4];
    for (int i = 0; i < 4; i++) begin
      s[i]  = col[31-8*i -: 8];
      m2[i] = xtime(s[i]);
      m4[i] = xtime(m2[i]);
      m8[i] = xtime(m4[i]);
      me[i] = m8[i] ^ m4[i] ^ m2[i];
      mb[i] = m8[i] ^ m2[i] ^ s[i];
      md[i] = m8[i] ^ m4[i] ^ s[i];
      m9[i] = m8[i] ^ s[i];
    end
    for (int i = 0; i < 4; i++) begin
      r[i] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  logic        out_valid_d, out_valid_q;
  logic [31:0] out_column_d, out_column_q;
  logic        use_inv;

  // When the inverse path is compiled out, inv is a don't-care.
  assign use_inv = ENABLE_INV && inv;

  // Next-state: load a new result on an accepted input, otherwise hold.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    out_valid_d  = in_valid;
    out_column_d = out_column_q;
    if (in_valid) begin
      out_column_d = use_inv ? inv_mix(in_column) : fwd_mix(in_column);
    end
  end

  // Output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_column_q <= 32'h0000_0000;
    end else begin
      out_valid_q  <= out_valid_d;
      out_column_q <= out_column_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_column = out_column_q;

endmodule

// File: tb/tb_mix_single_column.sv
// Self-checking bench for mix_single_column: directed AES vectors plus
// randomized traffic against a generic GF(2^8) matrix-multiply model.
module tb_mix_single_column;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        inv;
  logic [31:0] in_column;
  logic        out_valid, out_valid_f;
  logic [31:0] out_column, out_column_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mix_single_column #(.ENABLE_INV(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inv(inv),
    .in_column(in_column), .out_valid(out_valid), .out_column(out_column)
  );

  mix_single_column #(.ENABLE_INV(1'b0)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inv(inv),
    .in_column(in_column), .out_valid(out_valid_f), .out_column(out_column_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Schoolbook GF(2^8) multiply modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  // Circulant matrix times column; row i uses base[(j - i) mod 4] for s_j.
  function automatic logic [31:0] mix_ref(input logic [31:0] col, input logic inv_mode);
    logic [7:0] base [4];
    logic [7:0] s [4];
    logic [7:0] r [4];
    if (inv_mode) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else          base = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int j = 0; j < 4; j++) s[j] = col[31-8*j -: 8];
    for (int i = 0; i < 4; i++) begin
      r[i] = 8'h00;
      for (int j = 0; j < 4; j++) r[i] ^= gmul(base[(j - i + 4) % 4], s[j]);
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  task automatic drive(input logic v, input logic m, input logic [31:0] c);
    in_valid  = v;
    inv       = m;
    in_column = c;
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic m, input logic [31:0] c,
                          input logic [31:0] exp);
    drive(1'b1, m, c);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check(tag, out_column, exp);
  endtask

  logic [31:0] exp_col, exp_col_f, held;
  logic        exp_v;

  initial begin
    rst_n = 1'b0;
    // Reset while in_valid=1 must still clear everything.
    drive(1'b1, 1'b0, $urandom);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_col", out_column, 32'h0);
    check("rst_col_f", out_column_f, 32'h0);
    rst_n = 1'b1;

    directed("fwd0", 1'b0, 32'hd4bf5d30, 32'h046681e5);
    directed("fwd1", 1'b0, 32'he0b452ae, 32'he0cb199a);
    directed("fwd2", 1'b0, 32'hb84111f1, 32'h48f8d37a);
    directed("fwd3", 1'b0, 32'hdb135345, 32'h8e4da1bc);
    directed("ident", 1'b0, 32'h01010101, 32'h01010101);
    directed("zero", 1'b0, 32'h00000000, 32'h00000000);
    directed("inv0", 1'b1, 32'h046681e5, 32'hd4bf5d30);
    directed("inv1", 1'b1, 32'h8e4da1bc, 32'hdb135345);
    drive(1'b1, 1'b1, 32'hd4bf5d30);
    check("noinv_valid", {31'd0, out_valid_f}, 32'd1);
    check("noinv", out_column_f, 32'h046681e5);

    // Back-to-back with alternating mode.
    directed("b2b0", 1'b0, 32'hd4bf5d30, 32'h046681e5);
    directed("b2b1", 1'b1, 32'h046681e5, 32'hd4bf5d30);
    directed("b2b2", 1'b0, 32'he0b452ae, 32'he0cb199a);

    // Valid gap: inputs toggling with in_valid=0 must not disturb outputs.
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'($urandom), $urandom);
      check("gap_valid", {31'd0, out_valid}, 32'd0);
      check("gap_col", out_column, 32'he0cb199a);
    end

    // Accepted input then reset: result discarded, no valid pulse.
    directed("pre_rst", 1'b0, 32'hb84111f1, 32'h48f8d37a);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'hdb135345);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_col", out_column, 32'h0);
    rst_n = 1'b1;
    directed("post_rst", 1'b0, 32'hdb135345, 32'h8e4da1bc);

    // Randomized traffic against the reference model.
    exp_col   = out_column;
    exp_col_f = out_column_f;
    for (int k = 0; k < 400; k++) begin
      logic        v, m;
      logic [31:0] c;
      v = ($urandom_range(3) != 0);
      m = 1'($urandom);
      c = $urandom;
      drive(v, m, c);
      exp_v = v;
      if (v) begin
        exp_col   = mix_ref(c, m);
        exp_col_f = mix_ref(c, 1'b0);
      end
      check("rnd_valid", {31'd0, out_valid}, {31'd0, exp_v});
      check("rnd_col", out_column, exp_col);
      check("rnd_valid_f", {31'd0, out_valid_f}, {31'd0, exp_v});
      check("rnd_col_f", out_column_f, exp_col_f);
    end

    held = out_column;
    drive(1'b0, 1'b0, 32'h0);
    check("final_hold", out_column, held);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mix_single_column.md
MIX_SINGLE_COLUMN -- requirements
Module: mix_single_column

Interface
REQ-001 The block SHALL have parameter ENABLE_INV, default 1, meaning the inverse MixColumns datapath is present when 1 and absent when 0.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_column and inv are valid this cycle.
REQ-005 The block SHALL have port inv, input, 1 bit: 0 selects forward MixColumns, 1 selects InvMixColumns.
REQ-006 The block SHALL have port in_column, input, 32 bits: one AES state column.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_column holds a new result this cycle.
REQ-008 The block SHALL have port out_column, output, 32 bits: the transformed column.

Function
REQ-009 Byte mapping SHALL be s0=in_column[31:24] (row 0), s1=[23:16], s2=[15:8], s3=[7:0]; out_column uses the same mapping for r0..r3.
REQ-010 All multiplication SHALL be in GF(2^8) with reduction polynomial x^8+x^4+x^3+x+1 (0x11B); addition SHALL be XOR.
REQ-011 The xtime(b) operation SHALL be (b<<1) XOR (0x1B if b[7]=1, else 0x00), truncated to 8 bits.
REQ-012 Forward mode SHALL compute r0=2s0^3s1^s2^s3.
REQ-013 Forward mode SHALL compute r1=s0^2s1^3s2^s3.
REQ-014 Forward mode SHALL compute r2=s0^s1^2s2^3s3.
REQ-015 Forward mode SHALL compute r3=3s0^s1^s2^2s3.
REQ-016 Inverse mode SHALL use the matrix rows [0E 0B 0D 09], [09 0E 0B 0D], [0D 09 0E 0B], [0B 0D 09 0E], applied in the same row/column order.
REQ-017 The datapath SHALL be purely combinational XOR/xtime logic, with no lookup tables and no multi-cycle iteration.
REQ-018 Latency SHALL be 1 cycle: when in_valid=1 at edge N, out_column SHALL hold the result and out_valid SHALL be 1 after edge N.
REQ-019 When in_valid=0 at an edge, out_valid SHALL be 0 after that edge and out_column SHALL hold its previous value.
REQ-020 The block SHALL accept back-to-back inputs every cycle, with one result per accepted input and no backpressure.
REQ-021 The inv input SHALL be sampled together with in_column, so each accepted input can use a different mode.
REQ-022 When ENABLE_INV=0, inv SHALL be ignored and forward mode SHALL always be used.
REQ-023 Inputs applied while in_valid=0 SHALL have no effect on any output.

Reset
REQ-024 While rst_n=0 at a rising clk edge, out_valid SHALL become 0 and out_column SHALL become 32'h00000000, regardless of in_valid.
REQ-025 A reset in the cycle after an accepted input SHALL discard that result, with no out_valid pulse.
REQ-026 After rst_n returns to 1, the first in_valid=1 SHALL produce a result 1 cycle later as normal.
REQ-027 The block SHALL have no state other than out_valid and out_column.

Verification
REQ-028 Forward, inv=0: in_column d4bf5d30 -> out_column 046681e5; e0b452ae -> e0cb199a; b84111f1 -> 48f8d37a; db135345 -> 8e4da1bc; each with out_valid=1 one cycle after in_valid.
REQ-029 Identity and zero, inv=0: 01010101 -> 01010101 and 00000000 -> 00000000.
REQ-030 Inverse, inv=1: 046681e5 -> d4bf5d30 and 8e4da1bc -> db135345; with ENABLE_INV=0 and inv=1, d4bf5d30 -> 046681e5.
REQ-031 Back-to-back with alternating inv over three cycles: d4bf5d30 fwd, 046681e5 inv, e0b452ae fwd -> outputs 046681e5, d4bf5d30, e0cb199a on consecutive cycles with out_valid held at 1.
REQ-032 Valid gap: in_valid=0 for 2 cycles after a result -> out_valid=0 and out_column unchanged.
REQ-033 Reset mid-stream: rst_n=0 for one edge while in_valid=1 -> out_valid=0 and out_column=00000000, then normal results resume.
